// File: rtl/banner_scroll_ctrl_if.sv
// Command bus into the banner scroll sequencer: valid/ready handshake plus
// the op/dir/count payload offered by the board control logic.
interface banner_scroll_ctrl_if #(
  parameter int unsigned CNT_W = 8
) ();
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic             cmd_dir;
  logic [CNT_W-1:0] cmd_count;

  modport master (
    output cmd_valid,
    output cmd_op,
    output cmd_dir,
    output cmd_count,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_op,
    input  cmd_dir,
    input  cmd_count,
    output cmd_ready
  );
endinterface

// File: rtl/banner_scroll_ctrl.sv
// Command-driven scroll sequencer for the rotating LED banner (MOVE/PAUSE/HOME/RUN).
// Define BANNER_CMD_FIFO_EN to place a 4-entry command FIFO ahead of the sequencer.
module banner_scroll_ctrl #(
  parameter int unsigned W        = 10,
  parameter int unsigned TICK_DIV = 15_000_000,
  parameter int unsigned CNT_W    = 8,
  localparam int unsigned PW      = (W > 1) ? $clog2(W) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  banner_scroll_ctrl_if.slave  cmd,
  input  logic                 abort,
  output logic                 step,
  output logic                 step_dir,
  output logic [PW-1:0]        pos,
  output logic                 busy,
  output logic                 done
);

  localparam int unsigned PSW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned RW  = (CNT_W > PW) ? CNT_W : PW;

  localparam logic [1:0] OpMove  = 2'd0;
  localparam logic [1:0] OpPause = 2'd1;
  localparam logic [1:0] OpHome  = 2'd2;

  localparam logic [1:0] StIdle       = 2'd0;
  localparam logic [1:0] StRunSteps   = 2'd1;
  localparam logic [1:0] StPauseTicks = 2'd2;
  localparam logic [1:0] StFreeRun    = 2'd3;

  localparam logic [PW-1:0]  PosMax  = PW'(W - 1);
  localparam logic [PW-1:0]  PosHalf = PW'(W / 2);
  localparam logic [PSW-1:0] PscLast = PSW'(TICK_DIV - 1);

  logic [1:0]     state_q, state_d;
  logic [PSW-1:0] psc_q, psc_d;
  logic [RW-1:0]  rem_q, rem_d;
  logic           dir_q, dir_d;
  logic [PW-1:0]  pos_q, pos_d, pos_next;
  logic           step_q, step_d;
  logic           step_dir_q, step_dir_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic           tick;
  logic           fin;

  // Command presented to the sequencer and the strobe that loads it.
  logic             ld;
  logic [1:0]       ld_op;
  logic             ld_dir;
  logic [CNT_W-1:0] ld_count;

`ifdef BANNER_CMD_FIFO_EN
  localparam int unsigned FifoDepth = 4;

  typedef struct packed {
    logic [1:0]       op;
    logic             dir;
    logic [CNT_W-1:0] count;
  } cmd_t;

  cmd_t       fifo_q [FifoDepth];
  logic [1:0] wr_ptr_q, rd_ptr_q;
  logic [2:0] cnt_q;
  logic       push, pop, full, empty, flush;

  assign full          = (cnt_q == 3'd4);
  assign empty         = (cnt_q == 3'd0);
  assign cmd.cmd_ready = !full;
  assign push          = cmd.cmd_valid & !full;
  assign ld            = !busy_q & !empty;
  assign pop           = ld;
  assign flush         = abort & busy_q;
  assign ld_op         = fifo_q[rd_ptr_q].op;
  assign ld_dir        = fifo_q[rd_ptr_q].dir;
  assign ld_count      = fifo_q[rd_ptr_q].count;

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_q[wr_ptr_q] <= '{op: cmd.cmd_op, dir: cmd.cmd_dir, count: cmd.cmd_count};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= 2'd0;
      rd_ptr_q <= 2'd0;
      cnt_q    <= 3'd0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + 2'd1;
      end
      // Flush only happens while busy, so it never races a pop; a same-cycle push survives.
      if (flush) begin
        rd_ptr_q <= wr_ptr_q;
        cnt_q    <= {2'b00, push};
      end else begin
        if (pop) begin
          rd_ptr_q <= rd_ptr_q + 2'd1;
        end
        cnt_q <= cnt_q + {2'b00, push} - {2'b00, pop};
      end
    end
  end
`else
  assign cmd.cmd_ready = !busy_q;
  assign ld            = cmd.cmd_valid & !busy_q;
  assign ld_op         = cmd.cmd_op;
  assign ld_dir        = cmd.cmd_dir;
  assign ld_count      = cmd.cmd_count;
`endif

  assign tick = (psc_q == PscLast);

  always_comb begin
    if (dir_q) begin
      pos_next = (pos_q == PosMax) ? '0 : pos_q + PW'(1);
    end else begin
      pos_next = (pos_q == '0) ? PosMax : pos_q - PW'(1);
    end
  end

  always_comb begin
    state_d    = state_q;
    psc_d      = tick ? '0 : psc_q + PSW'(1);
    rem_d      = rem_q;
    dir_d      = dir_q;
    pos_d      = pos_q;
    step_d     = 1'b0;
    step_dir_d = step_dir_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    fin        = 1'b0;

    unique case (state_q)
      StIdle: begin
        psc_d = '0;
        if (ld) begin
          busy_d = 1'b1;
          dir_d  = ld_dir;
          rem_d  = RW'(ld_count);
          unique case (ld_op)
            OpMove:  state_d = StRunSteps;
            OpPause: state_d = StPauseTicks;
            OpHome: begin
              // Shortest way back to 0; a tie at W/2 goes right.
              state_d = StRunSteps;
              dir_d   = (pos_q > PosHalf);
              rem_d   = (pos_q > PosHalf) ? RW'(W - pos_q) : RW'(pos_q);
            end
            default: state_d = StFreeRun;
          endcase
        end
      end

      StRunSteps: begin
        if (rem_q == '0) begin
          fin = 1'b1;
        end else if (tick) begin
          step_d     = 1'b1;
          step_dir_d = dir_q;
          pos_d      = pos_next;
          rem_d      = abort ? '0 : rem_q - RW'(1);
        end else if (abort) begin
          fin = 1'b1;
        end
      end

      StPauseTicks: begin
        if ((rem_q == '0) || abort) begin
          fin = 1'b1;
        end else if (tick) begin
          rem_d = rem_q - RW'(1);
        end
      end

      StFreeRun: begin
        if (tick) begin
          step_d     = 1'b1;
          step_dir_d = dir_q;
          pos_d      = pos_next;
          // A step landing on the abort cycle completes; done follows one cycle later.
          if (abort) begin
            state_d = StRunSteps;
            rem_d   = '0;
          end
        end else if (abort) begin
          fin = 1'b1;
        end
      end

      default: state_d = StIdle;
    endcase

    if (fin) begin
      state_d = StIdle;
      busy_d  = 1'b0;
      done_d  = 1'b1;
      psc_d   = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      psc_q      <= '0;
      rem_q      <= '0;
      dir_q      <= 1'b0;
      pos_q      <= '0;
      step_q     <= 1'b0;
      step_dir_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      psc_q      <= psc_d;
      rem_q      <= rem_d;
      dir_q      <= dir_d;
      pos_q      <= pos_d;
      step_q     <= step_d;
      step_dir_q <= step_dir_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign step     = step_q;
  assign step_dir = step_dir_q;
  assign pos      = pos_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_banner_scroll_ctrl.sv
// Randomised bench for banner_scroll_ctrl against a timeline model: each accepted
// command is described by its accept edge, and outputs follow from elapsed cycles.
module tb_banner_scroll_ctrl;
  localparam int unsigned W  = 10;
  localparam int unsigned TD = 4;
  localparam int unsigned CW = 8;
  localparam int unsigned PW = 4;

  localparam int OP_MOVE  = 0;
  localparam int OP_PAUSE = 1;
  localparam int OP_HOME  = 2;
  localparam int OP_RUN   = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          abort;
  logic          step, step_dir, busy, done;
  logic [PW-1:0] pos;

  banner_scroll_ctrl_if #(.CNT_W(CW)) bif ();

  banner_scroll_ctrl #(.W(W), .TICK_DIV(TD), .CNT_W(CW)) dut (
    .clk      (clk),
    .rst      (rst),
    .cmd      (bif),
    .abort    (abort),
    .step     (step),
    .step_dir (step_dir),
    .pos      (pos),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  int nvec, nerr, ecyc, nsteps;

  // Model of the command in flight.
  bit m_act, m_acc, m_end, m_dir, idle_abort;
  int m_t0, m_op, m_n, m_pos, cur_abort_at, nxt_abort_at;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", tag, got, exp, ecyc);
    end
  endtask

  task automatic model_edge(output bit e_step, output bit e_dir, output bit e_done);
    int el;
    e_step = 1'b0;
    e_dir  = 1'b0;
    e_done = 1'b0;
    m_acc  = 1'b0;
    if (!m_act) begin
      if (bif.cmd_valid) begin
        m_act = 1'b1; m_acc = 1'b1; m_end = 1'b0; m_t0 = ecyc;
        m_op  = int'(bif.cmd_op); m_dir = bif.cmd_dir; m_n = int'(bif.cmd_count);
        cur_abort_at = nxt_abort_at;
        if (m_op == OP_HOME) begin
          if (m_pos <= W / 2) begin m_dir = 1'b0; m_n = m_pos; end
          else begin m_dir = 1'b1; m_n = W - m_pos; end
        end
      end
    end else begin
      el = ecyc - m_t0;
      if (m_end || (m_op != OP_RUN && el == TD * m_n + 1)) begin
        e_done = 1'b1;
        m_act  = 1'b0;
      end else begin
        if (el % TD == 0 && m_op != OP_PAUSE) begin
          e_step = 1'b1;
          e_dir  = m_dir;
          m_pos  = m_dir ? (m_pos + 1) % W : (m_pos + W - 1) % W;
        end
        if (abort) begin
          if (e_step) m_end = 1'b1;
          else begin e_done = 1'b1; m_act = 1'b0; end
        end
      end
    end
  endtask

  task automatic step_cycle();
    bit es, ed, edn;
    abort = m_act ? (cur_abort_at >= 0 && ecyc - m_t0 == cur_abort_at) : idle_abort;
    @(posedge clk);
    #1;
    model_edge(es, ed, edn);
    check_eq("step", step, es);
    check_eq("done", done, edn);
    check_eq("busy", busy, m_act);
    check_eq("cmd_ready", bif.cmd_ready, !m_act);
    check_eq("pos", pos, m_pos);
    if (es) check_eq("step_dir", step_dir, ed);
    if (step === 1'b1) nsteps++;
    ecyc++;
  endtask

  task automatic issue(input int op, input bit dir, input int cnt, input int ab_at);
    int guard;
    guard         = 0;
    bif.cmd_valid = 1'b1;
    bif.cmd_op    = op[1:0];
    bif.cmd_dir   = dir;
    bif.cmd_count = cnt[CW-1:0];
    nxt_abort_at  = ab_at;
    do begin
      step_cycle();
      guard++;
    end while (!m_acc && guard < 400);
    bif.cmd_valid = 1'b0;
    check_eq("accepted", m_acc, 1);
  endtask

  task automatic wait_idle();
    int guard;
    guard = 0;
    while (m_act && guard < 1000) begin
      step_cycle();
      guard++;
    end
    check_eq("idle_reached", m_act, 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_step"}, step, 0);
    check_eq({tag, "_step_dir"}, step_dir, 0);
    check_eq({tag, "_busy"}, busy, 0);
    check_eq({tag, "_done"}, done, 0);
    check_eq({tag, "_pos"}, pos, 0);
    check_eq({tag, "_ready"}, bif.cmd_ready, 1);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int s0;
    nvec = 0; nerr = 0; ecyc = 0; nsteps = 0;
    m_act = 1'b0; m_pos = 0; m_end = 1'b0; idle_abort = 1'b0;
    cur_abort_at = -1; nxt_abort_at = -1;
    bif.cmd_valid = 1'b0; bif.cmd_op = 2'd0; bif.cmd_dir = 1'b0; bif.cmd_count = '0;
    abort = 1'b0;
    rst   = 1'b1;
    #1;
    check_reset_outputs("reset");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    step_cycle();

    // Test-plan sequences.
    issue(OP_MOVE, 1'b1, 3, -1); wait_idle();
    check_eq("tp_move_left_pos", pos, 3);
    issue(OP_MOVE, 1'b0, 5, -1); wait_idle();
    check_eq("tp_move_right_wrap_pos", pos, 8);
    issue(OP_MOVE, 1'b0, 1, -1); wait_idle();
    issue(OP_HOME, 1'b0, 0, -1); wait_idle();
    check_eq("tp_home_from7_pos", pos, 0);
    s0 = nsteps;
    issue(OP_HOME, 1'b1, 7, -1); wait_idle();
    check_eq("tp_home_at0_steps", nsteps - s0, 0);
    issue(OP_MOVE, 1'b1, 5, -1); wait_idle();
    s0 = nsteps;
    issue(OP_HOME, 1'b1, 0, -1); wait_idle();
    check_eq("tp_home_tie_steps", nsteps - s0, 5);
    s0 = nsteps;
    issue(OP_RUN, 1'b1, 0, 10); wait_idle();
    check_eq("tp_run_abort_steps", nsteps - s0, 2);
    repeat (6) step_cycle();
    issue(OP_PAUSE, 1'b0, 2, -1);
    issue(OP_MOVE, 1'b1, 1, -1);
    wait_idle();
    idle_abort = 1'b1;
    step_cycle();
    idle_abort = 1'b0;
    step_cycle();

    // Randomised commands, sometimes offered while the previous one is still busy.
    for (int i = 0; i < 60; i++) begin
      int op, c, ab;
      bit d;
      op = int'($urandom_range(0, 3));
      d  = 1'($urandom_range(0, 1));
      c  = int'($urandom_range(0, 9));
      ab = -1;
      if (op == OP_RUN) ab = int'($urandom_range(1, 25));
      else if ($urandom_range(0, 3) == 0) ab = int'($urandom_range(1, TD * c + 2));
      issue(op, d, c, ab);
      if ($urandom_range(0, 1) == 1) begin
        wait_idle();
        if ($urandom_range(0, 3) == 0) begin
          idle_abort = 1'b1;
          step_cycle();
          idle_abort = 1'b0;
        end
      end
    end
    wait_idle();

    // Asynchronous reset in the middle of a MOVE.
    issue(OP_MOVE, 1'b1, 8, -1);
    repeat (9) step_cycle();
    #2;
    rst = 1'b1;
    #1;
    check_reset_outputs("rst_mid_move");
    m_act = 1'b0; m_pos = 0; m_end = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) step_cycle();
    issue(OP_MOVE, 1'b0, 2, -1); wait_idle();
    check_eq("post_reset_move_pos", pos, 8);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
